// File: rtl/seq_divider16_pkg.sv
// Shared definitions for the seq_divider16 iterative divider.
//   - state_t and the ST_* state constants for the control FSM
//   - DIV_WIDTH: operand / quotient / remainder width
//   - DBZ_QUOTIENT: quotient reported for an unsigned (or non-negative) divide by zero
// Optional build macro SEQ_DIVIDER16_SIGNED_EN adds the ST_FIXUP state.
package seq_divider16_pkg;

  localparam int DIV_WIDTH = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_CALC  = 2'd1;
  localparam state_t ST_DONE  = 2'd2;
`ifdef SEQ_DIVIDER16_SIGNED_EN
  localparam state_t ST_FIXUP = 2'd3;
`endif

  localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/seq_divider16_sub16_borrow.sv
// sub16_borrow: (WIDTH+1)-bit ripple subtractor that exposes the borrow-out.
// Built from the same full-adder cell chain as the ripple adder:
// diff = a + ~b + 1, and borrow is the inverted carry-out.
// Ports:
//   a      in  WIDTH+1  minuend
//   b      in  WIDTH+1  subtrahend
//   diff   out WIDTH+1  a - b (modulo 2^(WIDTH+1))
//   borrow out 1        1 when a < b
module sub16_borrow
  import seq_divider16_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  output logic [WIDTH:0] diff,
  output logic           borrow
);

  logic [WIDTH+1:0] carry;
  logic [WIDTH:0]   b_inv;

  assign b_inv    = ~b;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_cell
    assign diff[i]      = a[i] ^ b_inv[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b_inv[i]) | (carry[i] & (a[i] ^ b_inv[i]));
  end

  assign borrow = ~carry[WIDTH+1];

endmodule

// File: rtl/seq_divider16.sv
// seq_divider16: iterative restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   start         begin a division (taken only while ready=1)
//   dividend      numerator, sampled on the accepted start
//   divisor       denominator, sampled on the accepted start
//   ready         high in IDLE and DONE
//   done          one-cycle pulse, results valid from this cycle
//   quotient      result, held until the next accepted start completes
//   remainder     result, held likewise
//   div_by_zero   divisor was zero; valid with done, held with the results
// Handshake: start is accepted on a rising edge where start=1 and ready=1;
// start while busy is ignored. done marks the first cycle the results are valid.
// Build macro SEQ_DIVIDER16_SIGNED_EN: two's-complement operands, with one extra
// sign fix-up cycle (latency WIDTH+2 instead of WIDTH+1).
module seq_divider16
  import seq_divider16_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t         state;
  logic [CW-1:0]  count;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] divisor_r;

  logic [WIDTH:0]   rem_shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] dbz_quo;

`ifdef SEQ_DIVIDER16_SIGNED_EN
  logic neg_q;
  logic neg_r;

  // The unsigned core always sees magnitudes; signs are restored in FIXUP.
  assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign dbz_quo = dividend[WIDTH-1] ? WIDTH'(1) : DBZ_QUOTIENT;
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign dbz_quo = DBZ_QUOTIENT;
`endif

  // Partial remainder is kept below the divisor, so the shifted value needs
  // one extra bit; that bit is why the subtractor is WIDTH+1 wide.
  assign rem_shifted = {rem_r, quo_r[WIDTH-1]};

  sub16_borrow #(.WIDTH(WIDTH)) u_sub (
    .a      (rem_shifted),
    .b      ({1'b0, divisor_r}),
    .diff   (trial),
    .borrow (borrow)
  );

  assign rem_next = borrow ? rem_shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_next = {quo_r[WIDTH-2:0], ~borrow};

  assign ready = (state == ST_IDLE) || (state == ST_DONE);
  assign done  = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      count       <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      divisor_r   <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER16_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            count     <= CW'(WIDTH);
            divisor_r <= dvs_mag;
`ifdef SEQ_DIVIDER16_SIGNED_EN
            neg_q     <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r     <= dividend[WIDTH-1];
`endif
            if (divisor == '0) begin
              // Short-circuit: results are known immediately.
              state       <= ST_DONE;
              quotient    <= dbz_quo;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              rem_r <= '0;
              quo_r <= dvd_mag;
              state <= ST_CALC;
            end
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_CALC: begin
          rem_r <= rem_next;
          quo_r <= quo_next;
          count <= count - 1'b1;
          if (count == CW'(1)) begin
`ifdef SEQ_DIVIDER16_SIGNED_EN
            state <= ST_FIXUP;
`else
            state       <= ST_DONE;
            quotient    <= quo_next;
            remainder   <= rem_next;
            div_by_zero <= 1'b0;
`endif
          end
        end

`ifdef SEQ_DIVIDER16_SIGNED_EN
        ST_FIXUP: begin
          state       <= ST_DONE;
          quotient    <= neg_q ? -quo_r : quo_r;
          remainder   <= neg_r ? -rem_r : rem_r;
          div_by_zero <= 1'b0;
        end
`endif

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
